// File: rtl/frame_bank_sequencer.sv
// Capture/detect bank sequencer: rotates the camera writer and the classifier reader
// through 2**BANK_W frame banks, reports dropped frames and guards detect with a watchdog.
module frame_bank_sequencer #(
  parameter int ADDR_W  = 15,
  parameter int BANK_W  = 1,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run_mode,
  input  logic                     go,
  input  logic                     cap_done,
  input  logic                     detect_done,
  input  logic                     write_en_in,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [ADDR_W-1:0]        classifier_rd_addr,
  output logic [ADDR_W+BANK_W-1:0] wr_addr_out,
  output logic [ADDR_W+BANK_W-1:0] rd_addr_out,
  output logic                     write_en_out,
  output logic                     detect_en,
  output logic                     busy,
  output logic                     frame_drop,
  output logic                     timeout_err
);

  localparam int              NUM_BANKS = 2 ** BANK_W;
  localparam logic [TO_W-1:0] WD_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {C_IDLE, C_WAIT_SOF, C_WRITE} cap_state_t;
  typedef enum logic       {D_IDLE, D_RUN}               det_state_t;

  cap_state_t           cap_state;
  det_state_t           det_state;
  logic                 cap_done_z;
  logic                 go_latched;
  logic [NUM_BANKS-1:0] full;
  logic [NUM_BANKS-1:0] full_clr;
  logic [BANK_W-1:0]    cap_bank;
  logic [BANK_W-1:0]    cap_bank_nxt;
  logic [BANK_W-1:0]    det_bank;
  logic [TO_W-1:0]      wd_cnt;
  logic                 rise;
  logic                 wd_expired;
  logic                 det_release;
  logic                 cap_store;
  logic                 next_free;

  assign rise         = cap_done & ~cap_done_z;
  assign cap_bank_nxt = cap_bank + BANK_W'(1);
  assign wd_expired   = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
  assign det_release  = (det_state == D_RUN) && (detect_done || wd_expired);
  assign cap_store    = (cap_state == C_WRITE) && rise;

  // Bank occupancy as it will look after this cycle's detect release; the
  // free-running continue decision must see a bank the reader is just handing back.
  // NOTE: full_clr gets its default before the conditional update, so no latch is inferred.
  always_comb begin
    full_clr = full;
    if (det_release) full_clr[det_bank] = 1'b0;
  end

  assign next_free = ~full_clr[cap_bank_nxt];

  assign write_en_out = (cap_state == C_WRITE) & write_en_in;
  assign busy         = (cap_state != C_IDLE) | (det_state == D_RUN);
  assign wr_addr_out  = {cap_bank, wr_addr};
  assign rd_addr_out  = {det_bank, classifier_rd_addr};

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      full <= full_clr;
      // NOTE: the later non-blocking write to the same bit wins; set and clear never hit the same bank.
      if (cap_store) full[cap_bank] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_state  <= C_IDLE;
      cap_done_z <= 1'b0;
      go_latched <= 1'b0;
      cap_bank   <= '0;
      frame_drop <= 1'b0;
    end else begin
      cap_done_z <= cap_done;
      frame_drop <= 1'b0;
      case (cap_state)
        C_IDLE: begin
          if (go) go_latched <= 1'b1;
          if (rise && run_mode && full[cap_bank]) frame_drop <= 1'b1;
          if ((go_latched || run_mode) && !full[cap_bank]) cap_state <= C_WAIT_SOF;
        end
        C_WAIT_SOF: begin
          if (rise) begin
            cap_state  <= C_WRITE;
            go_latched <= 1'b0;
          end
        end
        C_WRITE: begin
          // The end-of-frame rise doubles as the next frame's start when streaming.
          if (rise) begin
            cap_bank <= cap_bank_nxt;
            if (!run_mode) begin
              cap_state <= C_IDLE;
            end else if (!next_free) begin
              frame_drop <= 1'b1;
              cap_state  <= C_IDLE;
            end
          end
        end
        default: cap_state <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      det_state   <= D_IDLE;
      det_bank    <= '0;
      wd_cnt      <= '0;
      detect_en   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (det_state)
        D_IDLE: begin
          if (full[det_bank]) begin
            det_state <= D_RUN;
            wd_cnt    <= '0;
            detect_en <= 1'b1;
          end
        end
        D_RUN: begin
          if (det_release) begin
            det_state   <= D_IDLE;
            det_bank    <= det_bank + BANK_W'(1);
            detect_en   <= 1'b0;
            timeout_err <= ~detect_done;
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_bank_sequencer.sv
// Self-checking bench: two sequencer configurations driven in parallel, each compared
// every cycle against a bank-occupancy reference model, plus directed scenario checks.
module tb_frame_bank_sequencer;

  localparam int AW  = 6;
  localparam int BW0 = 1;
  localparam int TO0 = 100;
  localparam int BW1 = 2;
  localparam int TO1 = 0;

  localparam int P_IDLE    = 0;
  localparam int P_ARMED   = 1;
  localparam int P_WRITING = 2;

  logic clk = 1'b0;
  logic rst, run_mode, go, cap_done, detect_done, write_en_in;
  logic [AW-1:0] wr_addr, rd_addr;

  logic [AW+BW0-1:0] wa0, ra0;
  logic              we0, de0, busy0, fd0, te0;
  logic [AW+BW1-1:0] wa1, ra1;
  logic              we1, de1, busy1, fd1, te1;

  always #5 clk = ~clk;

  frame_bank_sequencer #(.ADDR_W(AW), .BANK_W(BW0), .TIMEOUT(TO0), .TO_W(8)) u0 (
    .clk(clk), .rst(rst), .run_mode(run_mode), .go(go), .cap_done(cap_done),
    .detect_done(detect_done), .write_en_in(write_en_in), .wr_addr(wr_addr),
    .classifier_rd_addr(rd_addr), .wr_addr_out(wa0), .rd_addr_out(ra0),
    .write_en_out(we0), .detect_en(de0), .busy(busy0), .frame_drop(fd0),
    .timeout_err(te0)
  );

  frame_bank_sequencer #(.ADDR_W(AW), .BANK_W(BW1), .TIMEOUT(TO1), .TO_W(8)) u1 (
    .clk(clk), .rst(rst), .run_mode(run_mode), .go(go), .cap_done(cap_done),
    .detect_done(detect_done), .write_en_in(write_en_in), .wr_addr(wr_addr),
    .classifier_rd_addr(rd_addr), .wr_addr_out(wa1), .rd_addr_out(ra1),
    .write_en_out(we1), .detect_en(de1), .busy(busy1), .frame_drop(fd1),
    .timeout_err(te1)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: banks tracked as a ring of pending frames (count + pointers).
  int nb  [2] = '{2, 4};
  int tmo [2] = '{TO0, TO1};
  int wr_ptr[2], rd_ptr[2], pending[2], phase[2], elapsed[2];
  bit go_pend[2], det_run[2], drop_q[2], tout_q[2];
  bit cd_prev;
  bit auto_done;

  int n_we, n_den_rise, n_den_hi, n_drop, n_tout;
  bit de0_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_addr(input int bank, input logic [AW-1:0] a);
    return (64'(bank) << AW) | 64'(a);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      wr_ptr[d] = 0; rd_ptr[d] = 0; pending[d] = 0; phase[d] = P_IDLE; elapsed[d] = 0;
      go_pend[d] = 0; det_run[d] = 0; drop_q[d] = 0; tout_q[d] = 0;
    end
    cd_prev = 0;
  endtask

  task automatic model_step();
    bit rise;
    rise = cap_done && !cd_prev;
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      bit clr, tout, store, drop, gp_old;
      int p_old;
      p_old  = pending[d];
      gp_old = go_pend[d];
      clr    = det_run[d] && (detect_done || (tmo[d] != 0 && elapsed[d] == tmo[d] - 1));
      tout   = det_run[d] && !detect_done && tmo[d] != 0 && elapsed[d] == tmo[d] - 1;
      store  = 0;
      drop   = 0;
      case (phase[d])
        P_IDLE: begin
          if (go) go_pend[d] = 1;
          if (rise && run_mode && p_old == nb[d]) drop = 1;
          if ((gp_old || run_mode) && p_old < nb[d]) phase[d] = P_ARMED;
        end
        P_ARMED: begin
          if (rise) begin
            phase[d]   = P_WRITING;
            go_pend[d] = 0;
          end
        end
        default: begin
          if (rise) begin
            store = 1;
            if (!run_mode) phase[d] = P_IDLE;
            else if (p_old + 1 - int'(clr) >= nb[d]) begin
              drop     = 1;
              phase[d] = P_IDLE;
            end
          end
        end
      endcase
      pending[d] = p_old + int'(store) - int'(clr);
      wr_ptr[d]  = (wr_ptr[d] + int'(store)) % nb[d];
      rd_ptr[d]  = (rd_ptr[d] + int'(clr)) % nb[d];
      if (det_run[d]) begin
        if (clr) det_run[d] = 0;
        else elapsed[d]++;
      end else if (p_old > 0) begin
        det_run[d] = 1;
        elapsed[d] = 0;
      end
      drop_q[d] = drop;
      tout_q[d] = tout;
    end
    cd_prev = cap_done;
  endtask

  task automatic cmp_dut(input int d, input logic we, input logic [63:0] wa, input logic [63:0] ra,
                         input logic de, input logic bz, input logic fd, input logic te);
    string p;
    p = (d == 0) ? "u0" : "u1";
    check({p, ".write_en_out"}, 64'(we), 64'(phase[d] == P_WRITING && write_en_in));
    check({p, ".wr_addr_out"}, wa, mem_addr(wr_ptr[d], wr_addr));
    check({p, ".rd_addr_out"}, ra, mem_addr(rd_ptr[d], rd_addr));
    check({p, ".detect_en"}, 64'(de), 64'(det_run[d]));
    check({p, ".busy"}, 64'(bz), 64'(phase[d] != P_IDLE || det_run[d]));
    check({p, ".frame_drop"}, 64'(fd), 64'(drop_q[d]));
    check({p, ".timeout_err"}, 64'(te), 64'(tout_q[d]));
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_dut(0, we0, 64'(wa0), 64'(ra0), de0, busy0, fd0, te0);
    cmp_dut(1, we1, 64'(wa1), 64'(ra1), de1, busy1, fd1, te1);
    if (we0) n_we++;
    if (de0) n_den_hi++;
    if (de0 && !de0_prev) n_den_rise++;
    if (fd0) n_drop++;
    if (te0) n_tout++;
    de0_prev = de0;
    @(posedge clk);
    model_step();
    #1;
    wr_addr = AW'($urandom);
    rd_addr = AW'($urandom);
    if (auto_done) detect_done = det_run[0] && elapsed[0] >= 2;
    #1;
  endtask

  task automatic idle(input int n);
    cap_done = 0;
    repeat (n) tick();
  endtask

  task automatic frame(input int len);
    cap_done = 1;
    tick();
    cap_done = 0;
    repeat (len - 1) tick();
  endtask

  task automatic clear_counts();
    n_we = 0; n_den_rise = 0; n_den_hi = 0; n_drop = 0; n_tout = 0; de0_prev = 0;
  endtask

  task automatic reset_dut();
    rst = 1; go = 0; cap_done = 0; detect_done = 0; auto_done = 0;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1; run_mode = 0; go = 0; cap_done = 0; detect_done = 0; write_en_in = 0;
    wr_addr = '0; rd_addr = '0; auto_done = 0;
    model_reset();
    clear_counts();
    @(posedge clk);
    #2;
    tick();
    tick();
    rst = 0;
    check("rst.detect_en", 64'(de0), 64'(0));
    check("rst.busy", 64'(busy0), 64'(0));
    check("rst.write_en_out", 64'(we0), 64'(0));
    check("rst.frame_drop", 64'(fd0), 64'(0));
    check("rst.timeout_err", 64'(te0), 64'(0));
    check("rst.wr_bank", 64'(wa0[AW]), 64'(0));

    // Single-shot capture with a go pulse that must be ignored mid-frame.
    clear_counts();
    run_mode = 0; write_en_in = 1;
    go = 1; tick(); go = 0;
    idle(3);
    cap_done = 1; tick(); cap_done = 0;
    tick();
    go = 1; tick(); go = 0;
    check("ss.wr_bank", 64'(wa0[AW]), 64'(0));
    repeat (5) tick();
    cap_done = 1; tick(); cap_done = 0;
    check("ss.detect_lat1", 64'(de0), 64'(0));
    tick();
    check("ss.detect_lat2", 64'(de0), 64'(1));
    check("ss.rd_bank", 64'(ra0[AW]), 64'(0));
    check("ss.write_cycles", 64'(n_we), 64'(8));
    idle(2);
    detect_done = 1; tick(); detect_done = 0;
    check("ss.detect_off", 64'(de0), 64'(0));
    idle(2);
    check("ss.idle_busy", 64'(busy0), 64'(0));
    frame(6);
    frame(6);
    check("ss.no_rearm_writes", 64'(n_we), 64'(8));

    // Free-running with prompt detect completion: four frames, no drops.
    reset_dut();
    clear_counts();
    run_mode = 1; auto_done = 1;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      write_en_in = $urandom_range(0, 1);
      frame(12);
    end
    run_mode = 0;
    frame(12);
    idle(10);
    check("fr.detect_count", 64'(n_den_rise), 64'(4));
    check("fr.frame_drop", 64'(n_drop), 64'(0));
    check("fr.timeout_err", 64'(n_tout), 64'(0));

    // Free-running with detect withheld: third end rise drops, then rearm.
    reset_dut();
    clear_counts();
    run_mode = 1; write_en_in = 1;
    idle(2);
    frame(10);
    frame(10);
    frame(10);
    check("wh.frame_drop", 64'(n_drop), 64'(1));
    check("wh.capture_idle_we", 64'(we0), 64'(0));
    detect_done = 1; tick(); detect_done = 0;
    idle(3);
    cap_done = 1; tick(); cap_done = 0;
    check("wh.rearm_we", 64'(we0), 64'(1));
    check("wh.rearm_bank", 64'(wa0[AW]), 64'(0));
    check("wh.no_second_drop", 64'(n_drop), 64'(1));

    // Watchdog: detect_done never arrives.
    reset_dut();
    clear_counts();
    run_mode = 0; write_en_in = 0;
    go = 1; tick(); go = 0;
    idle(3);
    frame(5);
    cap_done = 1; tick(); cap_done = 0;
    idle(115);
    check("wd.detect_cycles", 64'(n_den_hi), 64'(TO0));
    check("wd.timeout_pulses", 64'(n_tout), 64'(1));
    check("wd.detect_runs", 64'(n_den_rise), 64'(1));
    check("wd.bank_freed_busy", 64'(busy0), 64'(0));

    // Detect frees the next bank in the same cycle as the capture end rise.
    reset_dut();
    clear_counts();
    run_mode = 1; write_en_in = 1;
    idle(2);
    frame(10);
    frame(10);
    cap_done = 1; detect_done = 1; tick(); cap_done = 0; detect_done = 0;
    check("sc.frame_drop", 64'(fd0), 64'(0));
    check("sc.still_writing", 64'(we0), 64'(1));
    check("sc.wr_bank", 64'(wa0[AW]), 64'(0));
    tick();
    tick();
    check("sc.detect_next", 64'(de0), 64'(1));
    check("sc.drop_count", 64'(n_drop), 64'(0));

    // Reset while writing and detecting, with go held high.
    rst = 1; go = 1; tick(); rst = 0; go = 0;
    check("mr.detect_en", 64'(de0), 64'(0));
    check("mr.busy", 64'(busy0), 64'(0));
    check("mr.write_en_out", 64'(we0), 64'(0));
    check("mr.wr_bank", 64'(wa0[AW]), 64'(0));
    check("mr.rd_bank", 64'(ra0[AW]), 64'(0));
    run_mode = 0;
    idle(4);
    check("mr.go_ignored", 64'(busy0), 64'(0));

    // Randomized traffic against the reference model.
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) run_mode = ~run_mode;
      go          = ($urandom_range(0, 29) == 0);
      cap_done    = ($urandom_range(0, 15) == 0);
      detect_done = ($urandom_range(0, 7) == 0);
      write_en_in = $urandom_range(0, 1);
      rst         = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 0; go = 0; cap_done = 0; detect_done = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/frame_bank_sequencer.md
# frame_bank_sequencer

Parametrised capture/detect sequencer for the face-detection pipeline. It manages 2**BANK_W frame banks in the dual-port frame memory so the camera capture path writes one bank while the classifier reads a previously completed one. Supports single-shot (go-triggered) and free-running modes, frame-drop reporting, and a detect watchdog. It sits between the capture module, the frame memory and the detect module.

## Interface
- ADDR_W, 15: in-bank pixel address width.
- BANK_W, 1: bank index width; NUM_BANKS = 2**BANK_W, BANK_W >= 1.
- TIMEOUT, 0: detect watchdog in clk cycles; 0 disables it.
- TO_W, 24: watchdog counter width; TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- run_mode  in  1  0 = single-shot, 1 = free-running.
- go  in  1  single-shot capture request pulse.
- cap_done  in  1  capture module frame-boundary level; its rising edge marks frame start/end.
- detect_done  in  1  detect module completion pulse.
- write_en_in  in  1  pixel write strobe from capture.
- wr_addr  in  ADDR_W  pixel address from capture.
- classifier_rd_addr  in  ADDR_W  read address from detect.
- wr_addr_out  out  ADDR_W+BANK_W  {cap_bank, wr_addr}, memory port A.
- rd_addr_out  out  ADDR_W+BANK_W  {det_bank, classifier_rd_addr}, memory port B.
- write_en_out  out  1  write_en_in gated to C_WRITE.
- detect_en  out  1  detect module enable; high for the whole of D_RUN.
- busy  out  1  capture state != C_IDLE or detect state == D_RUN.
- frame_drop  out  1  1-cycle pulse: a frame was skipped because no bank was free.
- timeout_err  out  1  1-cycle pulse: watchdog expired.

## Operation
- rise = cap_done & ~cap_done_z. cap_done_z is registered and resets to 0.
- State: full[NUM_BANKS-1:0], cap_bank, det_bank, go_latched, capture FSM, detect FSM, watchdog counter. All reset to 0 / IDLE.
- Capture FSM:
  - C_IDLE:
    - go sets go_latched.
    - When (go_latched | run_mode) and !full[cap_bank], go to C_WAIT_SOF.
    - A rise in C_IDLE while run_mode=1 and full[cap_bank]=1 pulses frame_drop.
  - C_WAIT_SOF: on rise, go to C_WRITE and clear go_latched.
  - C_WRITE: write_en_out = write_en_in. On rise:
    - set full[cap_bank];
    - cap_bank <= cap_bank+1 (mod NUM_BANKS);
    - if run_mode=1 and the next bank is free (after same-cycle detect clear), stay in C_WRITE; this frame-end rise is also the next frame's start;
    - if run_mode=1 and the next bank is full, pulse frame_drop and go to C_IDLE;
    - if run_mode=0, go to C_IDLE.
  - go in any state other than C_IDLE is ignored. run_mode may change at any time and takes effect at the next decision point.
- Detect FSM:
  - D_IDLE: if full[det_bank], go to D_RUN and clear the watchdog.
  - D_RUN: detect_en=1.
    - On detect_done, or on watchdog count == TIMEOUT-1 with TIMEOUT != 0: clear full[det_bank], det_bank <= det_bank+1, go to D_IDLE.
    - The timeout case also pulses timeout_err.
    - detect_done in D_IDLE is ignored.
- Set and clear of full in the same cycle always hit different banks (capture only writes an empty bank). The next-bank free check uses the post-clear value.
- Banks are consumed strictly in order. det_bank never passes cap_bank.

## Timing
- Registered outputs: detect_en, frame_drop, timeout_err. Combinational outputs: busy (from state regs); write_en_out, wr_addr_out and rd_addr_out (from state regs and inputs).
- Reset values: detect_en=0, frame_drop=0, timeout_err=0, write_en_out=0, busy=0, wr_addr_out={0,wr_addr}, rd_addr_out={0,classifier_rd_addr}.
- Rise seen in cycle n → full set at edge n+1 → detect_en high from edge n+2. Latency is 2 clocks.
- detect_done in cycle m → detect_en low from edge m+1 → bank freed at edge m+1.
- write_en_out is active in C_WRITE from the edge after the start rise up to and including the end-rise cycle.
- Watchdog: detect_en stays high for exactly TIMEOUT cycles when detect_done never arrives.
- rst mid-frame: every state, flag and bank index clears at the next edge. Any partial bank is discarded.

## Test plan
- Single-shot, BANK_W=1, run_mode=0: go, then rises at t0 and t1 → write_en_out follows write_en_in only between them, wr_addr_out MSB=0, detect_en high 2 clocks after t1, rd_addr_out MSB=0.
- Free-running, BANK_W=1, detect_done returned promptly: 4 frames → banks written 0,1,0,1, no frame_drop, detect_en asserted 4 times.
- Free-running, detect_done withheld: frame 0 → bank 0, frame 1 → bank 1; the third frame-end rise pulses frame_drop and capture goes to C_IDLE. After detect_done, capture rearms at the next rise.
- TIMEOUT=100, detect_done never sent: detect_en high exactly 100 cycles, timeout_err pulses once, bank freed.
- Same-cycle detect_done freeing the next bank and capture end rise (run_mode=1, BANK_W=1) → capture stays in C_WRITE, no frame_drop.
- rst asserted mid-C_WRITE and in D_RUN: next cycle all outputs at reset values, full=0; go ignored outside C_IDLE.
